// File: rtl/note_spawn_scheduler.sv
// Note spawn sequencer for the 4-lane playfield: LFSR lane pick, busy-lane skip,
// programmable inter-spawn gap, and a valid/ready handoff to the lane datapath.
module note_spawn_scheduler #(
    parameter int          GAP_TICKS  = 24,
    parameter int          MAX_ACTIVE = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        aclk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  speed_sel,
    input  logic [3:0]  lane_busy,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [1:0]  spawn_lane,
    output logic [4:0]  spawn_speed,
    output logic [15:0] spawn_count,
    output logic [1:0]  state_dbg
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PICK  = 2'b01,
        ST_ISSUE = 2'b10,
        ST_GAP   = 2'b11
    } state_t;

    state_t             state_r;
    logic [15:0]        lfsr_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               spawn_valid_r;
    logic [1:0]         spawn_lane_r;
    logic [4:0]         spawn_speed_r;
    logic [15:0]        spawn_count_r;
    logic [2:0]         cand_s;
    logic               can_issue_s;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [4:0] speed_decode(input logic [1:0] sel);
        logic [4:0] s;
        case (sel)
            2'b00:   s = 5'd1;
            2'b01:   s = 5'd5;
            2'b10:   s = 5'd10;
            2'b11:   s = 5'd20;
            default: s = 5'd1;
        endcase
        return s;
    endfunction

    // Returns {found, lane}; scanning downward lets the nearest free lane after base win.
    function automatic logic [2:0] find_lane(input logic [1:0] base, input logic [3:0] busy);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (!busy[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Candidate lane and issue permission for the PICK state.
    always_comb begin
        cand_s      = find_lane(lfsr_r[1:0], lane_busy);
        can_issue_s = 1'b0;
        if (!pause && cand_s[2] && (popcount4(lane_busy) < 3'(MAX_ACTIVE))) begin
            can_issue_s = 1'b1;
        end else begin
            can_issue_s = 1'b0;
        end
    end

    // Scheduler FSM, free-running LFSR and registered spawn outputs.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            lfsr_r        <= LFSR_SEED;
            gap_cnt_r     <= '0;
            spawn_valid_r <= 1'b0;
            spawn_lane_r  <= 2'b00;
            spawn_speed_r <= 5'd0;
            spawn_count_r <= 16'h0000;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            case (state_r)
                ST_IDLE: begin
                    spawn_valid_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_PICK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PICK: begin
                    if (!start) begin
                        state_r <= ST_IDLE;
                    end else if (can_issue_s) begin
                        state_r       <= ST_ISSUE;
                        spawn_lane_r  <= cand_s[1:0];
                        spawn_speed_r <= speed_decode(speed_sel);
                        spawn_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_PICK;
                    end
                end
                // start and pause are deliberately ignored until the handshake completes.
                ST_ISSUE: begin
                    if (spawn_valid_r && spawn_ready) begin
                        spawn_valid_r <= 1'b0;
                        spawn_count_r <= spawn_count_r + 16'd1;
                        gap_cnt_r     <= GAP_W'(GAP_TICKS - 1);
                        state_r       <= start ? ST_GAP : ST_IDLE;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_GAP: begin
                    if (!start) begin
                        state_r <= ST_IDLE;
                    end else if (pause) begin
                        gap_cnt_r <= gap_cnt_r;
                    end else if (gap_cnt_r == '0) begin
                        state_r <= ST_PICK;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    spawn_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign spawn_valid = spawn_valid_r;
    assign spawn_lane  = spawn_lane_r;
    assign spawn_speed = spawn_speed_r;
    assign spawn_count = spawn_count_r;
    assign state_dbg   = state_r;

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// Scoreboard bench for note_spawn_scheduler: expected spawns are queued when the
// bench releases a pick, then popped and compared when spawn_valid appears.
module tb_note_spawn_scheduler;

    localparam int          GAP_TICKS  = 4;
    localparam int          MAX_ACTIVE = 2;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef struct packed {
        logic [1:0] lane;
        logic [4:0] speed;
    } spawn_t;

    logic        aclk;
    logic        reset_n;
    logic        start;
    logic        pause;
    logic [1:0]  speed_sel;
    logic [3:0]  lane_busy;
    logic        spawn_ready;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic [4:0]  spawn_speed;
    logic [15:0] spawn_count;
    logic [1:0]  state_dbg;

    logic [15:0] lfsr_m;
    logic [15:0] exp_count;
    logic [2:0]  gap_obs;
    spawn_t      sb_q[$];
    spawn_t      exp_s;
    int          total;
    int          bad;

    note_spawn_scheduler #(
        .GAP_TICKS  (GAP_TICKS),
        .MAX_ACTIVE (MAX_ACTIVE),
        .LFSR_SEED  (LFSR_SEED)
    ) dut (
        .aclk        (aclk),
        .reset_n     (reset_n),
        .start       (start),
        .pause       (pause),
        .speed_sel   (speed_sel),
        .lane_busy   (lane_busy),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_speed (spawn_speed),
        .spawn_count (spawn_count),
        .state_dbg   (state_dbg)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference Galois LFSR, stepped exactly like the one the scheduler uses.
    always @(posedge aclk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= LFSR_SEED;
        else          lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [4:0] speed_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd1;
            2'b01:   return 5'd5;
            2'b10:   return 5'd10;
            default: return 5'd20;
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] lane, input logic [4:0] speed);
        spawn_t e;
        e.lane  = lane;
        e.speed = speed;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; speed_sel = 2'b00;
        lane_busy = 4'b0000; spawn_ready = 1'b0;
        repeat (2) @(negedge aclk);
        reset_n = 1'b1;
        sb_q.delete();
        exp_count = 16'h0000;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        reset_n = 1'b1; start = 1'b1;
        repeat (2) @(negedge aclk);
        total++;
        if (spawn_valid !== 1'b1) begin
            bad++; $display("FAIL reset_pre_issue: valid=%b want 1", spawn_valid);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (spawn_valid !== 1'b0 || spawn_count !== 16'h0000 || state_dbg !== 2'b00) begin
            bad++; $display("FAIL reset_async: valid=%b count=%h state=%b want 0/0000/00",
                            spawn_valid, spawn_count, state_dbg);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            start = 1'($urandom); pause = 1'($urandom); speed_sel = 2'($urandom);
            lane_busy = 4'($urandom); spawn_ready = 1'($urandom);
            total++;
            if ({spawn_valid, spawn_lane, spawn_speed, spawn_count, state_dbg} !== 26'd0) begin
                bad++; $display("FAIL reset_hold: v=%b l=%h s=%h c=%h st=%b want all 0",
                                spawn_valid, spawn_lane, spawn_speed, spawn_count, state_dbg);
            end
        end
        @(negedge aclk);
        reset_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            total++;
            if (state_dbg !== 2'b00 || spawn_valid !== 1'b0) begin
                bad++; $display("FAIL reset_idle: state=%b valid=%b want 00/0", state_dbg, spawn_valid);
            end
        end
    endtask

    task automatic test_cadence();
        do_reset();
        start = 1'b1; spawn_ready = 1'b1; speed_sel = 2'b01;
        @(negedge aclk);
        total++;
        if (state_dbg !== 2'b01) begin
            bad++; $display("FAIL cad_pick: state=%b want 01", state_dbg);
        end
        for (int n = 0; n < 3; n++) begin
            push_exp(lfsr_m[1:0], speed_of(speed_sel));
            @(negedge aclk);
            exp_s = sb_q.pop_front();
            total++;
            if (spawn_valid !== 1'b1 || spawn_lane !== exp_s.lane || spawn_speed !== exp_s.speed) begin
                bad++; $display("FAIL cad_spawn%0d: v=%b lane=%0d speed=%0d want 1/%0d/%0d", n,
                                spawn_valid, spawn_lane, spawn_speed, exp_s.lane, exp_s.speed);
            end
            @(negedge aclk);
            exp_count++;
            total++;
            if (spawn_valid !== 1'b0 || spawn_count !== exp_count) begin
                bad++; $display("FAIL cad_count%0d: v=%b count=%h want 0/%h", n,
                                spawn_valid, spawn_count, exp_count);
            end
            if (n < 2) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge aclk);
                    total++;
                    if (spawn_valid !== 1'b0) begin
                        bad++; $display("FAIL cad_gap%0d_%0d: valid=%b want 0", n, k, spawn_valid);
                    end
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] base_t [3];
        logic [3:0] busy_t [3];
        logic [1:0] lane_t [3];
        int waited;
        base_t = '{2'd2, 2'd2, 2'd3};
        busy_t = '{4'b0000, 4'b0100, 4'b1000};
        lane_t = '{2'd2, 2'd3, 2'd0};
        do_reset();
        start = 1'b1; pause = 1'b1; speed_sel = 2'b10;
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            waited = 0;
            while (lfsr_m[1:0] !== base_t[i] && waited < 64) begin
                @(negedge aclk);
                waited++;
            end
            total++;
            if (waited >= 64) begin
                bad++; $display("FAIL rot_wait%0d: waited=%0d want <64", i, waited);
            end
            lane_busy = busy_t[i]; pause = 1'b0;
            push_exp(lane_t[i], speed_of(speed_sel));
            @(negedge aclk);
            exp_s = sb_q.pop_front();
            total++;
            if (spawn_valid !== 1'b1 || spawn_lane !== exp_s.lane || spawn_speed !== exp_s.speed) begin
                bad++; $display("FAIL rot_lane%0d: v=%b lane=%0d speed=%0d want 1/%0d/%0d", i,
                                spawn_valid, spawn_lane, spawn_speed, exp_s.lane, exp_s.speed);
            end
            spawn_ready = 1'b1;
            @(negedge aclk);
            spawn_ready = 1'b0;
            exp_count++;
            total++;
            if (spawn_valid !== 1'b0 || spawn_count !== exp_count) begin
                bad++; $display("FAIL rot_count%0d: v=%b count=%h want 0/%h", i,
                                spawn_valid, spawn_count, exp_count);
            end
            repeat (4) @(negedge aclk);
            pause = 1'b1;
        end
    endtask

    task automatic test_max_active();
        logic [1:0] lane_e;
        do_reset();
        start = 1'b1; lane_busy = 4'b0011; speed_sel = 2'b00;
        @(negedge aclk);
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            total++;
            if (spawn_valid !== 1'b0 || state_dbg !== 2'b01) begin
                bad++; $display("FAIL max_block%0d: v=%b state=%b want 0/01", k, spawn_valid, state_dbg);
            end
        end
        lane_busy = 4'b0001;
        lane_e = (lfsr_m[1:0] == 2'd0) ? 2'd1 : lfsr_m[1:0];
        push_exp(lane_e, speed_of(speed_sel));
        @(negedge aclk);
        exp_s = sb_q.pop_front();
        total++;
        if (spawn_valid !== 1'b1 || spawn_lane !== exp_s.lane || spawn_lane === 2'd0 ||
            spawn_speed !== exp_s.speed) begin
            bad++; $display("FAIL max_release: v=%b lane=%0d speed=%0d want 1/%0d/%0d",
                            spawn_valid, spawn_lane, spawn_speed, exp_s.lane, exp_s.speed);
        end
    endtask

    task automatic test_issue_hold();
        do_reset();
        start = 1'b1; speed_sel = 2'b11;
        @(negedge aclk);
        push_exp(lfsr_m[1:0], speed_of(speed_sel));
        @(negedge aclk);
        exp_s = sb_q.pop_front();
        for (int k = 0; k < 10; k++) begin
            total++;
            if (spawn_valid !== 1'b1 || spawn_lane !== exp_s.lane || spawn_speed !== exp_s.speed ||
                spawn_count !== exp_count) begin
                bad++; $display("FAIL hold%0d: v=%b lane=%0d speed=%0d count=%h want 1/%0d/%0d/%h", k,
                                spawn_valid, spawn_lane, spawn_speed, spawn_count,
                                exp_s.lane, exp_s.speed, exp_count);
            end
            speed_sel = 2'(k); lane_busy = 4'($urandom); pause = 1'(k); start = 1'(k + 1);
            @(negedge aclk);
        end
        start = 1'b1; pause = 1'b0; spawn_ready = 1'b1;
        @(negedge aclk);
        spawn_ready = 1'b0;
        exp_count++;
        total++;
        if (spawn_valid !== 1'b0 || spawn_count !== exp_count || state_dbg !== 2'b11) begin
            bad++; $display("FAIL hold_accept: v=%b count=%h state=%b want 0/%h/11",
                            spawn_valid, spawn_count, state_dbg, exp_count);
        end
    endtask

    task automatic test_gap_pause_wrap();
        do_reset();
        start = 1'b1; spawn_ready = 1'b1; speed_sel = 2'b01;
        @(negedge aclk);
        push_exp(lfsr_m[1:0], speed_of(speed_sel));
        @(negedge aclk);
        exp_s = sb_q.pop_front();
        total++;
        if (spawn_valid !== 1'b1 || spawn_lane !== exp_s.lane) begin
            bad++; $display("FAIL gp_spawn: v=%b lane=%0d want 1/%0d", spawn_valid, spawn_lane, exp_s.lane);
        end
        @(negedge aclk);
        exp_count++;
        gap_obs = dut.gap_cnt_r;
        total++;
        if (spawn_count !== exp_count || state_dbg !== 2'b11 || gap_obs !== 3'd3) begin
            bad++; $display("FAIL gp_enter: count=%h state=%b gap=%0d want %h/11/3",
                            spawn_count, state_dbg, gap_obs, exp_count);
        end
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            gap_obs = dut.gap_cnt_r;
            total++;
            if (gap_obs !== 3'd3 || state_dbg !== 2'b11) begin
                bad++; $display("FAIL gp_pause%0d: gap=%0d state=%b want 3/11", k, gap_obs, state_dbg);
            end
        end
        pause = 1'b0;
        @(negedge aclk);
        gap_obs = dut.gap_cnt_r;
        total++;
        if (gap_obs !== 3'd2) begin
            bad++; $display("FAIL gp_resume: gap=%0d want 2", gap_obs);
        end
        start = 1'b0;
        @(negedge aclk);
        total++;
        if (state_dbg !== 2'b00 || spawn_valid !== 1'b0) begin
            bad++; $display("FAIL gp_stop: state=%b valid=%b want 00/0", state_dbg, spawn_valid);
        end
        force dut.spawn_count_r = 16'hFFFF;
        #1;
        release dut.spawn_count_r;
        exp_count = 16'hFFFF;
        total++;
        if (spawn_count !== exp_count) begin
            bad++; $display("FAIL wrap_preset: count=%h want %h", spawn_count, exp_count);
        end
        start = 1'b1;
        @(negedge aclk);
        push_exp(lfsr_m[1:0], speed_of(speed_sel));
        @(negedge aclk);
        exp_s = sb_q.pop_front();
        total++;
        if (spawn_valid !== 1'b1 || spawn_lane !== exp_s.lane) begin
            bad++; $display("FAIL wrap_spawn: v=%b lane=%0d want 1/%0d", spawn_valid, spawn_lane, exp_s.lane);
        end
        @(negedge aclk);
        exp_count++;
        total++;
        if (spawn_count !== exp_count || spawn_count !== 16'h0000) begin
            bad++; $display("FAIL wrap_count: count=%h want %h", spawn_count, exp_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; speed_sel = 2'b00;
        lane_busy = 4'b0000; spawn_ready = 1'b0; exp_count = 16'h0000;
        test_reset();
        test_cadence();
        test_rotation();
        test_max_active();
        test_issue_hold();
        test_gap_pause_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
